// File: rtl/andn_pipe_if.sv
// Sample-side and result-side signals of the pipelined AND/NAND reducer.
// The producer uses the master modport and the reducer uses the slave modport.
interface andn_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1
);
    logic                      en;
    logic                      in_valid;
    logic                      nand_mode;
    logic [CHANNELS*WIDTH-1:0] i;
    logic                      out_valid;
    logic [CHANNELS-1:0]       q;

    modport master (output en, in_valid, nand_mode, i, input out_valid, q);
    modport slave  (input en, in_valid, nand_mode, i, output out_valid, q);
endinterface

// File: rtl/andn_pipe.sv
// Pipelined CHANNELS x WIDTH-input AND/NAND reduction. A register bank follows
// every STAGE_LEVELS tree levels, and the last bank drives q/out_valid directly.
module andn_pipe #(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 1,
    parameter int STAGE_LEVELS = 2
) (
    input logic        ck,
    input logic        nrst,
    andn_pipe_if.slave io
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int STAGES = (LEVELS == 0) ? 1 : (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;

    function automatic int ops_at(input int lvl);
        int n;
        n = WIDTH;
        for (int k = 0; k < lvl; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int IN_LVL  = s * STAGE_LEVELS;
        localparam int OUT_LVL = (IN_LVL + STAGE_LEVELS > LEVELS) ? LEVELS : IN_LVL + STAGE_LEVELS;
        localparam int IN_W    = ops_at(IN_LVL);
        localparam int OUT_W   = ops_at(OUT_LVL);
        localparam int GROUP   = 1 << (OUT_LVL - IN_LVL);
        localparam bit LAST    = (s == STAGES - 1);

        logic [CHANNELS-1:0][IN_W-1:0]  data_in;
        logic                           valid_in;
        logic                           mode_in;
        logic [CHANNELS-1:0][OUT_W-1:0] reduced;
        logic [CHANNELS-1:0][OUT_W-1:0] data_next;
        logic [CHANNELS-1:0][OUT_W-1:0] data;
        logic                           valid;

        if (s == 0) begin : g_head
            assign data_in  = io.i;
            assign valid_in = io.in_valid;
            assign mode_in  = io.nand_mode;
        end else begin : g_link
            assign data_in  = g_stage[s-1].data;
            assign valid_in = g_stage[s-1].valid;
            assign mode_in  = g_stage[s-1].g_mode.mode;
        end

        // After this stage's levels, operand j is the AND of incoming operands
        // j*GROUP .. j*GROUP+GROUP-1; operands beyond IN_W act as the constant-1 pad.
        always_comb begin
            reduced = '1;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int b = 0; b < IN_W; b++) begin
                    reduced[c][b / GROUP] = reduced[c][b / GROUP] & data_in[c][b];
                end
            end
        end

        always_comb begin
            data_next = reduced;
            if (LAST && mode_in) begin
                data_next = ~reduced;
            end
        end

        always_ff @(posedge ck or negedge nrst) begin
            if (!nrst) begin
                valid <= 1'b0;
            end else if (io.en) begin
                valid <= valid_in;
            end
        end

        // Data holds through bubbles so q keeps the last valid result.
        always_ff @(posedge ck or negedge nrst) begin
            if (!nrst) begin
                data <= '0;
            end else if (io.en && valid_in) begin
                data <= data_next;
            end
        end

        if (!LAST) begin : g_mode
            logic mode;
            always_ff @(posedge ck or negedge nrst) begin
                if (!nrst) begin
                    mode <= 1'b0;
                end else if (io.en && valid_in) begin
                    mode <= mode_in;
                end
            end
        end
    end

    assign io.q         = g_stage[STAGES-1].data;
    assign io.out_valid = g_stage[STAGES-1].valid;
endmodule

// File: tb/tb_andn_pipe.sv
// Bench for andn_pipe: a default instance, a 2-channel WIDTH=5 instance and a
// WIDTH/STAGE_LEVELS sweep, all compared against a timestamped sample history.
module tb_andn_pipe;
    localparam int NSW = 10;
    localparam int SW_W   [NSW] = '{1, 1, 2, 2, 3, 3, 7, 7, 64, 64};
    localparam int SW_SL  [NSW] = '{1, 3, 1, 3, 1, 3, 1, 3, 1, 3};
    localparam int SW_LAT [NSW] = '{1, 1, 1, 1, 2, 1, 3, 1, 6, 2};

    typedef struct {
        bit          v;
        bit          m;
        logic [7:0]  a;
        logic [9:0]  b;
        logic [63:0] w;
    } push_t;

    logic           ck = 1'b0;
    logic           nrst;
    logic           en;
    logic           in_valid;
    logic           nand_mode;
    logic [7:0]     a_vec;
    logic [9:0]     b_vec;
    logic [63:0]    sw_vec;
    logic [NSW-1:0] sw_v;
    logic [NSW-1:0] sw_q;
    int             tests = 0;
    int             fails = 0;
    push_t          hist[$];

    always #5 ck = ~ck;

    andn_pipe_if #(.WIDTH(8), .CHANNELS(1)) ifa ();
    assign ifa.en        = en;
    assign ifa.in_valid  = in_valid;
    assign ifa.nand_mode = nand_mode;
    assign ifa.i         = a_vec;
    andn_pipe #(.WIDTH(8), .CHANNELS(1), .STAGE_LEVELS(2)) dut_a (
        .ck(ck), .nrst(nrst), .io(ifa.slave));

    andn_pipe_if #(.WIDTH(5), .CHANNELS(2)) ifb ();
    assign ifb.en        = en;
    assign ifb.in_valid  = in_valid;
    assign ifb.nand_mode = nand_mode;
    assign ifb.i         = b_vec;
    andn_pipe #(.WIDTH(5), .CHANNELS(2), .STAGE_LEVELS(2)) dut_b (
        .ck(ck), .nrst(nrst), .io(ifb.slave));

    for (genvar k = 0; k < NSW; k++) begin : g_sw
        andn_pipe_if #(.WIDTH(SW_W[k]), .CHANNELS(1)) sif ();
        assign sif.en        = en;
        assign sif.in_valid  = in_valid;
        assign sif.nand_mode = nand_mode;
        assign sif.i         = sw_vec[SW_W[k]-1:0];
        andn_pipe #(.WIDTH(SW_W[k]), .CHANNELS(1), .STAGE_LEVELS(SW_SL[k])) dut (
            .ck(ck), .nrst(nrst), .io(sif.slave));
        assign sw_v[k] = sif.out_valid;
        assign sw_q[k] = sif.q;
    end

    function automatic bit and_w(input logic [63:0] x, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (x & mask) == mask;
    endfunction

    // which: 0 = dut_a, 1 = dut_b, 2+k = sweep instance k
    function automatic logic [1:0] result_of(input push_t p, input int which);
        logic [1:0] r;
        if (which == 0) r = {1'b0, and_w(64'(p.a), 8)};
        else if (which == 1) r = {and_w(64'(p.b[9:5]), 5), and_w(64'(p.b[4:0]), 5)};
        else r = {1'b0, and_w(p.w, SW_W[which-2])};
        if (p.m) r = (which == 1) ? ~r : {1'b0, ~r[0]};
        return r;
    endfunction

    // A sample taken at the n-th en edge is visible after edge n + stg - 1.
    function automatic void expected(input int which, input int stg,
                                     output bit ev, output logic [1:0] eq);
        int n;
        bit found;
        n = hist.size();
        ev = 1'b0;
        eq = 2'b00;
        found = 1'b0;
        if (n >= stg) begin
            ev = hist[n-stg].v;
            for (int x = n - stg; x >= 0; x--) begin
                if (!found && hist[x].v) begin
                    eq = result_of(hist[x], which);
                    found = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [63:0] make_pattern(input int w);
        logic [63:0] r;
        case ($urandom_range(0, 2))
            0: r = '1;
            1: r = ~(64'd1 << $urandom_range(0, w - 1));
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit         ev;
        logic [1:0] eq;
        expected(0, 2, ev, eq);
        check_output({tag, " a.valid"}, 64'(ifa.out_valid), 64'(ev));
        check_output({tag, " a.q"}, 64'(ifa.q), 64'(eq[0]));
        expected(1, 2, ev, eq);
        check_output({tag, " b.valid"}, 64'(ifb.out_valid), 64'(ev));
        check_output({tag, " b.q"}, 64'(ifb.q), 64'(eq));
        for (int k = 0; k < NSW; k++) begin
            expected(k + 2, SW_LAT[k], ev, eq);
            check_output($sformatf("%s sw%0d.valid", tag, k), 64'(sw_v[k]), 64'(ev));
            check_output($sformatf("%s sw%0d.q", tag, k), 64'(sw_q[k]), 64'(eq[0]));
        end
    endtask

    task automatic apply_stimulus(input bit e, input bit v, input bit m,
                                  input logic [7:0] a, input logic [9:0] b, input logic [63:0] w);
        push_t p;
        en        = e;
        in_valid  = v;
        nand_mode = m;
        a_vec     = a;
        b_vec     = b;
        sw_vec    = w;
        @(posedge ck);
        if (nrst && e) begin
            p.v = v; p.m = m; p.a = a; p.b = b; p.w = w;
            hist.push_back(p);
        end
        #1;
    endtask

    initial begin
        logic [63:0] pa;
        logic [63:0] pb;
        logic [63:0] pw;
        int          lat_sw [NSW];
        int          lat_a;
        bit          stall_en [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        bit          stall_v  [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 0};

        nrst = 1'b0;
        en = 1'b0; in_valid = 1'b0; nand_mode = 1'b0;
        a_vec = '0; b_vec = '0; sw_vec = '0;

        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b1, 1'b1, 1'($urandom), 8'($urandom), 10'($urandom), {$urandom, $urandom});
            check_output("reset a.q", 64'(ifa.q), 64'd0);
            check_output("reset a.valid", 64'(ifa.out_valid), 64'd0);
            check_all("reset");
        end
        nrst = 1'b1;

        apply_stimulus(1'b1, 1'b1, 1'b0, 8'hFF, 10'($urandom), {$urandom, $urandom});
        check_output("basic e1 a.valid", 64'(ifa.out_valid), 64'd0);
        check_all("basic1");
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'hFE, 10'($urandom), {$urandom, $urandom});
        check_output("basic e2 a.valid", 64'(ifa.out_valid), 64'd1);
        check_output("basic e2 a.q", 64'(ifa.q), 64'd1);
        check_all("basic2");
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom), 10'($urandom), {$urandom, $urandom});
        check_output("basic e3 a.valid", 64'(ifa.out_valid), 64'd1);
        check_output("basic e3 a.q", 64'(ifa.q), 64'd0);
        check_all("basic3");

        apply_stimulus(1'b1, 1'b1, 1'b1, 8'($urandom), 10'h3EF, {$urandom, $urandom});
        check_all("mode1");
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'($urandom), 10'h3EF, {$urandom, $urandom});
        check_output("mode s1 b.q", 64'(ifb.q), 64'h1);
        check_all("mode2");
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'($urandom), 10'h3FF, {$urandom, $urandom});
        check_output("mode s2 b.q", 64'(ifb.q), 64'h2);
        check_all("mode3");
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom), 10'($urandom), {$urandom, $urandom});
        check_output("mode s3 b.q", 64'(ifb.q), 64'h0);
        check_output("mode s3 b.valid", 64'(ifb.out_valid), 64'd1);
        check_all("mode4");

        for (int s = 0; s < 9; s++) begin
            pa = make_pattern(8);
            pb = make_pattern(10);
            pw = make_pattern(SW_W[$urandom_range(0, NSW - 1)]);
            apply_stimulus(stall_en[s], stall_v[s], 1'($urandom), pa[7:0], pb[9:0], pw);
            check_all($sformatf("stall%0d", s));
        end

        for (int s = 0; s < 40; s++) begin
            pa = make_pattern(8);
            pb = make_pattern(10);
            pw = make_pattern(SW_W[$urandom_range(0, NSW - 1)]);
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), pa[7:0], pb[9:0], pw);
            check_all($sformatf("rand%0d", s));
        end

        nrst = 1'b0;
        hist.delete();
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'($urandom), 10'($urandom), {$urandom, $urandom});
        check_all("relat");
        nrst = 1'b1;
        lat_a = 0;
        for (int k = 0; k < NSW; k++) lat_sw[k] = 0;
        for (int e = 1; e <= 8; e++) begin
            apply_stimulus(1'b1, e == 1, 1'b0, 8'hFF, 10'h3FF, '1);
            check_all($sformatf("lat%0d", e));
            if (lat_a == 0 && ifa.out_valid) lat_a = e;
            for (int k = 0; k < NSW; k++) begin
                if (lat_sw[k] == 0 && sw_v[k]) lat_sw[k] = e;
            end
        end
        check_output("latency a", 64'(lat_a), 64'd2);
        for (int k = 0; k < NSW; k++) begin
            check_output($sformatf("latency sw%0d", k), 64'(lat_sw[k]), 64'(SW_LAT[k]));
            check_output($sformatf("ones sw%0d.q", k), 64'(sw_q[k]), 64'd1);
        end

        for (int s = 0; s < 3; s++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 8'hFF, 10'h3FF, '1);
            check_all($sformatf("prefill%0d", s));
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 10'h000, '0);
        check_all("inflight1");
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 10'h000, '0);
        check_all("inflight2");
        #3;
        nrst = 1'b0;
        hist.delete();
        #1;
        check_output("async a.q", 64'(ifa.q), 64'd0);
        check_output("async a.valid", 64'(ifa.out_valid), 64'd0);
        check_output("async b.q", 64'(ifb.q), 64'd0);
        check_all("async");
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 10'h000, '0);
        check_all("inreset");
        nrst = 1'b1;
        lat_a = 0;
        for (int e = 1; e <= 8; e++) begin
            apply_stimulus(1'b1, e == 1, 1'b0, 8'hFF, 10'h3FF, '1);
            check_all($sformatf("post%0d", e));
            if (lat_a == 0 && ifa.out_valid) lat_a = e;
        end
        check_output("post-reset latency a", 64'(lat_a), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
